// File: rtl/if_id_stage_if.sv
// Instruction-memory bus between the fetch stage and a combinational-read memory.
// master: drives instr_addr, samples instr_data. slave: the memory side.
interface if_id_stage_if;
  logic [31:0] instr_addr;
  logic [31:0] instr_data;

  modport master (
    output instr_addr,
    input  instr_data
  );

  modport slave (
    input  instr_addr,
    output instr_data
  );
endinterface

// File: rtl/if_id_stage.sv
// IF stage + IF/ID register: PC, fetch, load-use stall, branch flush, event counters.
// Ports: clk/reset, imem bus, branch/ID-EX hazard inputs, IF/ID outputs, stall/flush, counters.
module if_id_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  if_id_stage_if.master    imem,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  input  logic             idex_mem_read,
  input  logic [4:0]       idex_rt,
  output logic [31:0]      _pc_plus_four,
  output logic [31:0]      _instruction,
  output logic             _valid,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [31:0]      immediate,
  output logic             stall,
  output logic             flush,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  logic [31:0] pc;
  logic [31:0] pc_next4;
  logic [31:0] target;
  logic [5:0]  opcode;
  logic        uses_rt;
  logic        rs_hit;
  logic        rt_hit;

  assign pc_next4        = pc + 32'd4;
  assign target          = branch_target & ~32'h3;
  assign imem.instr_addr = pc;

  assign opcode    = _instruction[31:26];
  assign rs        = _instruction[25:21];
  assign rt        = _instruction[20:16];
  assign rd        = _instruction[15:11];
  assign immediate = {{16{_instruction[15]}},
                      _instruction[15:0]};

  // Only R-type, beq and sw actually read rt as a source.
  always_comb begin
    uses_rt = 1'b0;
    unique case (1'b1)
      opcode == 6'h00,
      opcode == 6'h04,
      opcode == 6'h2B: uses_rt = 1'b1;
      default:         uses_rt = 1'b0;
    endcase
  end

  assign rs_hit = (idex_rt == rs);
  assign rt_hit = uses_rt & (idex_rt == rt);
  assign stall  = _valid & idex_mem_read
                & (idex_rt != 5'd0)
                & (rs_hit | rt_hit);
  assign flush  = branch_taken;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc            <= RESET_PC;
      _instruction  <= '0;
      _pc_plus_four <= '0;
      _valid        <= 1'b0;
    end else if (branch_taken) begin
      pc            <= target;
      _instruction  <= '0;
      _pc_plus_four <= '0;
      _valid        <= 1'b0;
    end else if (!stall) begin
      pc            <= pc_next4;
      _instruction  <= imem.instr_data;
      _pc_plus_four <= pc_next4;
      _valid        <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (branch_taken && flush_count != '1)
        flush_count <= flush_count + 1'b1;
      if (stall && !branch_taken &&
          stall_count != '1)
        stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_if_id_stage.sv
// Randomised + directed bench for if_id_stage against a behavioural model.
// Two instances: defaults, and RESET_PC=FFFF_FFFC / CNT_W=2 for wrap/saturation.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        idex_mem_read;
  logic [4:0]  idex_rt;
  logic        ovr_en;
  logic [31:0] ovr;

  logic [31:0] ppf [2];
  logic [31:0] ins [2];
  logic        vld [2];
  logic [4:0]  rs_o [2];
  logic [4:0]  rt_o [2];
  logic [4:0]  rd_o [2];
  logic [31:0] imm [2];
  logic        stl [2];
  logic        fls [2];
  logic [15:0] sc0, fc0;
  logic [1:0]  sc1, fc1;

  int vectors = 0;
  int miscompares = 0;

  // model state
  logic [31:0] m_pc [2];
  logic [31:0] m_ins [2];
  logic [31:0] m_ppf [2];
  logic        m_vld [2];
  int          m_sc [2];
  int          m_fc [2];
  int          cmax [2];
  logic [31:0] rpc [2];

  always #5 clk = ~clk;

  if_id_stage_if imem0 ();
  if_id_stage_if imem1 ();

  assign imem0.instr_data = ovr_en ? ovr
                          : 32'h20 + imem0.instr_addr;
  assign imem1.instr_data = ovr_en ? ovr
                          : 32'h20 + imem1.instr_addr;

  if_id_stage u0 (
    .clk(clk), .reset(reset), .imem(imem0),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .idex_mem_read(idex_mem_read),
    .idex_rt(idex_rt),
    ._pc_plus_four(ppf[0]), ._instruction(ins[0]),
    ._valid(vld[0]), .rs(rs_o[0]), .rt(rt_o[0]),
    .rd(rd_o[0]), .immediate(imm[0]),
    .stall(stl[0]), .flush(fls[0]),
    .stall_count(sc0), .flush_count(fc0)
  );

  if_id_stage #(
    .RESET_PC(32'hFFFF_FFFC), .CNT_W(2)
  ) u1 (
    .clk(clk), .reset(reset), .imem(imem1),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .idex_mem_read(idex_mem_read),
    .idex_rt(idex_rt),
    ._pc_plus_four(ppf[1]), ._instruction(ins[1]),
    ._valid(vld[1]), .rs(rs_o[1]), .rt(rt_o[1]),
    .rd(rd_o[1]), .immediate(imm[1]),
    .stall(stl[1]), .flush(fls[1]),
    .stall_count(sc1), .flush_count(fc1)
  );

  function automatic logic [31:0] fetch(
    input logic [31:0] a);
    return ovr_en ? ovr : 32'h20 + a;
  endfunction

  // Load-use rule from the ISA view: the younger instruction
  // reads rs always, rt only for R-type / beq / sw.
  function automatic logic hazard(input int k);
    logic [5:0] op;
    logic reads_rt;
    op = m_ins[k][31:26];
    reads_rt = (op == 6'h00) || (op == 6'h04)
            || (op == 6'h2B);
    if (!m_vld[k] || !idex_mem_read) return 1'b0;
    if (idex_rt == 5'd0) return 1'b0;
    if (idex_rt == m_ins[k][25:21]) return 1'b1;
    return reads_rt && (idex_rt == m_ins[k][20:16]);
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h",
             tag, got, exp);
    end
  endtask

  task automatic cyc(input logic rst, input logic bt,
                     input logic [31:0] tgt,
                     input logic mr, input logic [4:0] r,
                     input logic oe, input logic [31:0] ov);
    logic [31:0] addr [2];
    logic [31:0] dat;
    logic        hz;
    reset = rst; branch_taken = bt;
    branch_target = tgt; idex_mem_read = mr;
    idex_rt = r; ovr_en = oe; ovr = ov;
    #1;
    addr[0] = imem0.instr_addr;
    addr[1] = imem1.instr_addr;
    for (int k = 0; k < 2; k++) begin
      hz = hazard(k);
      chk($sformatf("u%0d.instr_addr", k), addr[k], m_pc[k]);
      chk($sformatf("u%0d.instruction", k), ins[k], m_ins[k]);
      chk($sformatf("u%0d.pc_plus_four", k), ppf[k], m_ppf[k]);
      chk($sformatf("u%0d.valid", k), 32'(vld[k]), 32'(m_vld[k]));
      chk($sformatf("u%0d.rs", k), 32'(rs_o[k]), 32'(m_ins[k][25:21]));
      chk($sformatf("u%0d.rt", k), 32'(rt_o[k]), 32'(m_ins[k][20:16]));
      chk($sformatf("u%0d.rd", k), 32'(rd_o[k]), 32'(m_ins[k][15:11]));
      chk($sformatf("u%0d.immediate", k), imm[k],
          32'($signed(m_ins[k][15:0])));
      chk($sformatf("u%0d.stall", k), 32'(stl[k]), 32'(hz));
      chk($sformatf("u%0d.flush", k), 32'(fls[k]), 32'(bt));
      chk($sformatf("u%0d.stall_count", k),
          k == 0 ? 32'(sc0) : 32'(sc1), 32'(m_sc[k]));
      chk($sformatf("u%0d.flush_count", k),
          k == 0 ? 32'(fc0) : 32'(fc1), 32'(m_fc[k]));
      // next state from the stage's behavioural rules
      dat = fetch(m_pc[k]);
      if (rst) begin
        m_pc[k] = rpc[k]; m_ins[k] = 0; m_ppf[k] = 0;
        m_vld[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
      end else if (bt) begin
        m_pc[k] = {tgt[31:2], 2'b00};
        m_ins[k] = 0; m_ppf[k] = 0; m_vld[k] = 0;
        if (m_fc[k] < cmax[k]) m_fc[k]++;
      end else if (hz) begin
        if (m_sc[k] < cmax[k]) m_sc[k]++;
      end else begin
        m_ins[k] = dat;
        m_ppf[k] = m_pc[k] + 32'd4;
        m_vld[k] = 1'b1;
        m_pc[k] = m_pc[k] + 32'd4;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int n, input logic mr,
                     input logic [4:0] r, input logic oe,
                     input logic [31:0] ov);
    for (int i = 0; i < n; i++)
      cyc(1'b0, 1'b0, 32'h0, mr, r, oe, ov);
  endtask

  localparam logic [31:0] ADD  = 32'h0041_1820;
  localparam logic [31:0] ADDI = 32'h2024_0001;
  localparam logic [31:0] SW   = 32'hAC24_0000;
  localparam logic [31:0] LWR  = 32'h8C45_0004;

  initial begin
    logic [31:0] pool [4];
    pool[0] = ADD; pool[1] = ADDI;
    pool[2] = SW;  pool[3] = LWR;
    rpc[0] = 32'h0;  rpc[1] = 32'hFFFF_FFFC;
    cmax[0] = 65535; cmax[1] = 3;
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = 'x; m_ins[k] = 'x; m_ppf[k] = 'x;
      m_vld[k] = 'x; m_sc[k] = 0; m_fc[k] = 0;
    end
    reset = 1'b1; branch_taken = 1'b0;
    branch_target = 0; idex_mem_read = 1'b0;
    idex_rt = 0; ovr_en = 1'b0; ovr = 0;
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = rpc[k]; m_ins[k] = 0; m_ppf[k] = 0;
      m_vld[k] = 0;
    end

    // reset state, then free run (u1 wraps FFFF_FFFC -> 0)
    cyc(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 0);
    run(6, 1'b0, 0, 1'b0, 0);

    // load-use on rs
    run(1, 1'b0, 0, 1'b1, ADD);
    run(1, 1'b1, 5'd2, 1'b0, 0);
    run(2, 1'b0, 5'd2, 1'b0, 0);
    // idex_rt = 0 and mem_read = 0 never stall
    run(1, 1'b0, 0, 1'b1, ADD);
    run(1, 1'b1, 5'd0, 1'b1, ADD);
    run(1, 1'b0, 5'd2, 1'b1, ADD);

    // rt only matters for instructions that read it
    run(1, 1'b0, 0, 1'b1, ADDI);
    run(1, 1'b1, 5'd4, 1'b0, 0);
    run(1, 1'b0, 0, 1'b1, SW);
    run(1, 1'b1, 5'd4, 1'b0, 0);
    run(1, 1'b0, 0, 1'b0, 0);

    // branch to 0x40, then redirect to 0x103 -> 0x100
    cyc(1'b0, 1'b1, 32'h40, 1'b0, 0, 1'b0, 0);
    cyc(1'b0, 1'b1, 32'h103, 1'b0, 0, 1'b0, 0);
    run(2, 1'b0, 0, 1'b0, 0);

    // branch with a live hazard: redirect wins
    run(1, 1'b0, 0, 1'b1, ADD);
    cyc(1'b0, 1'b1, 32'h200, 1'b1, 5'd2, 1'b0, 0);
    run(2, 1'b0, 0, 1'b0, 0);

    // 5 consecutive stalls: u1 saturates at 3
    run(1, 1'b0, 0, 1'b1, ADD);
    run(5, 1'b1, 5'd2, 1'b1, ADD);
    run(1, 1'b0, 0, 1'b0, 0);

    // 5 flushes: u1 flush_count saturates too
    for (int i = 0; i < 5; i++)
      cyc(1'b0, 1'b1, 32'h300 + 32'(i), 1'b0, 0, 1'b0, 0);

    // reset during a stall
    run(1, 1'b0, 0, 1'b1, ADD);
    run(1, 1'b1, 5'd2, 1'b1, ADD);
    cyc(1'b1, 1'b0, 0, 1'b1, 5'd2, 1'b1, ADD);
    run(3, 1'b0, 0, 1'b0, 0);

    // randomised traffic
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 49) == 0,
          $urandom_range(0, 9) == 0,
          $urandom(),
          1'($urandom_range(0, 1)),
          5'($urandom_range(0, 6)),
          $urandom_range(0, 2) != 0,
          pool[$urandom_range(0, 3)]);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
